serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor built around one full-subtractor cell and a borrow flop; LSB first, one bit per clock.
- Area-lean counterpart to the combinational ripple-carry adder: computes a - b - bin.
- Start/busy/done handshake; sits beside the adder in the arithmetic library for control paths where latency is acceptable.

---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic             bit_d, br_n, accept, last;
`ifdef SERIAL_SUB_OVF_EN
   logic             am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif

   assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
   assign br_n   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign last   = cnt_q == LAST;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      am_d    = am_q;
      bm_d    = bm_q;
      ovf_d   = ovf_q;
`endif
      if (state_q == SHIFT) begin
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         r_d     = {bit_d, r_q[WIDTH-1:1]};
         br_d    = br_n;
         cnt_d   = cnt_q + 1'b1;
         state_d = last ? DONE : SHIFT;
         if (last) begin
            diff_d = {bit_d, r_q[WIDTH-1:1]};
            bout_d = br_n;
`ifdef SERIAL_SUB_OVF_EN
            ovf_d  = (am_q != bm_q) && (bit_d != am_q);
`endif
         end
      end else begin
         state_d = accept ? SHIFT : IDLE;
         if (accept) begin
            a_d   = a;
            b_d   = b;
            r_d   = '0;
            br_d  = bin;
            cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
            am_d  = a[WIDTH-1];
            bm_d  = b[WIDTH-1];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         am_q    <= 1'b0;
         bm_q    <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         am_q    <= am_d;
         bm_q    <= bm_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = state_q == SHIFT;
   assign done = state_q == DONE;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and exhaustive checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         bin = 1'b0;
   logic         busy, done, bout;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int n_chk = 0;
   int n_pass = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [W:0] model(input int x, input int y, input int c);
      return (W+1)'((x - y - c + (1 << (W+1))) % (1 << (W+1)));
   endfunction

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      @(negedge clk);
      a = x; b = y; bin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
   endtask

   task automatic wait_done(output int nb, output bit ok);
      nb = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            ok = 1'b1;
            return;
         end
         if (busy) nb++;
         @(negedge clk);
      end
   endtask

   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit full);
      int nb;
      bit ok;
      logic [W:0] e;
      e = model(int'(x), int'(y), int'(c));
      launch(x, y, c);
      wait_done(nb, ok);
      check("done_timeout", 32'(ok), 32'd1);
      check($sformatf("result %0d-%0d-%0d", x, y, c), 32'({bout, diff}), 32'(e));
      if (full) begin
         check("busy_cycles", 32'(nb), 32'(W));
         @(negedge clk);
         check("done_single_pulse", 32'(done), 32'd0);
      end
   endtask

   initial begin
      int nb;
      bit ok;
      bit seen;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      rst = 1'b0;

      op(4'd9, 4'd3, 1'b0, 1'b1);
      op(4'd3, 4'd9, 1'b0, 1'b1);
      op(4'd0, 4'd0, 1'b1, 1'b1);
      op(4'd15, 4'd15, 1'b0, 1'b1);

      // start during SHIFT must be ignored; start held in DONE chains immediately
      launch(4'd9, 4'd3, 1'b0);
      a = 4'd1; b = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(nb, ok);
      check("ign_timeout", 32'(ok), 32'd1);
      check("ign_result", 32'({bout, diff}), 32'(model(9, 3, 0)));
      a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_done", 32'(done), 32'd0);
      wait_done(nb, ok);
      check("b2b_timeout", 32'(ok), 32'd1);
      check("b2b_result", 32'({bout, diff}), 32'(model(5, 2, 0)));

      // reset mid-operation discards it
      launch(4'd9, 4'd3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_diff", 32'(diff), 32'd0);
      check("mid_rst_bout", 32'(bout), 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen |= done;
      end
      check("mid_rst_no_done", 32'(seen), 32'd0);

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++)
               op(W'(x), W'(y), 1'(c), 1'b0);

      repeat (40) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end

`ifdef SERIAL_SUB_OVF_EN
      op(4'd8, 4'd1, 1'b0, 1'b0);
      check("ovf_8_1", 32'(ovf), 32'd1);
      op(4'd7, 4'd1, 1'b0, 1'b0);
      check("ovf_7_1", 32'(ovf), 32'd0);
      op(4'd7, 4'd8, 1'b0, 1'b0);
      check("ovf_7_8", 32'(ovf), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
